counter_ext: RTL

//  Parametrised up/down counter; next generation of the basic 4-bit free-running counter.

---
 rtl/counter_ext.sv | 64 ++++++
 1 files changed

// File: rtl/counter_ext.sv
// counter_ext: up/down counter with wrap or saturate bounds, load, terminal-count and sticky overflow.
// Optional tick prescaler is enabled by defining COUNTER_PRESCALE_EN.
module counter_ext #(
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = (1 << WIDTH) - 1,
    parameter int PRESCALE_W = 8
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  ien,
    input  logic                  iup,
    input  logic                  isat,
    input  logic                  iload,
    input  logic [WIDTH-1:0]      idata,
    input  logic                  iclr_ovf,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] iprescale,
`endif
    output logic [WIDTH-1:0]      ocnt,
    output logic                  otc,
    output logic                  oovf
);
    localparam logic [WIDTH-1:0] max_v = WIDTH'(MAX_VAL);

    if (WIDTH < 1 || PRESCALE_W < 1 || MAX_VAL > (1 << WIDTH) - 1 || MAX_VAL < 0)
        $error("counter_ext: bad parameters");

    logic             tick, step, bound;
    logic [WIDTH-1:0] next_cnt, load_val;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre;
    assign tick = pre == iprescale;
    always_ff @(posedge iclk) begin
        if (!irst || iload)
            pre <= '0;
        else if (ien)
            pre <= tick ? '0 : pre + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        step     = ien & tick & ~iload;
        bound    = iup ? (ocnt == max_v) : (ocnt == '0);
        load_val = idata > max_v ? max_v : idata;
        next_cnt = iup ? (bound ? (isat ? max_v : '0) : ocnt + 1'b1)
                       : (bound ? (isat ? '0 : max_v) : ocnt - 1'b1);
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            ocnt <= '0;
            otc  <= 1'b0;
            oovf <= 1'b0;
        end else begin
            ocnt <= iload ? load_val : step ? next_cnt : ocnt;
            otc  <= step & bound;
            // a boundary step in the same cycle as a clear keeps the flag set
            oovf <= (step & bound) | (oovf & ~iclr_ovf);
        end
    end
endmodule
